// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
// Shared definitions for the sequential ALU unit:
//   op_t        - 4-bit opcode encoding (11..15 are illegal)
//   state_t     - control FSM states
//   FLAG_*_BIT  - bit positions of the flags inside the LED flag byte
// No ports; imported by the interface, the LED mux and the top.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOR = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_SLT = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8,
    OP_SRA = 4'd9,
    OP_MUL = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MULT,
    DONE
  } state_t;

  localparam int FLAG_ZF_BIT   = 0;
  localparam int FLAG_OF_BIT   = 1;
  localparam int FLAG_ERR_BIT  = 2;
  localparam int FLAG_BUSY_BIT = 3;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if
// Operand/result handshake bundle for seq_alu_unit.
//   in_valid_xi/in_ready_xo   : operand + opcode handshake (op_xi, a_xi, b_xi)
//   out_valid_xo/out_ready_xi : result handshake (f_xo plus zf/of/err flags)
//   busy_xo                   : multiply in progress
//   led_sel_xi/led_xo         : LED byte select and drive
// Modports: master (operand source / result sink), slave (the ALU unit).
interface seq_alu_if #(
  parameter int WIDTH     = 32,
  parameter int LED_SEL_W = $clog2(WIDTH/8 + 1)
);
  logic                 in_valid_xi;
  logic                 in_ready_xo;
  logic [3:0]           op_xi;
  logic [WIDTH-1:0]     a_xi;
  logic [WIDTH-1:0]     b_xi;
  logic                 out_valid_xo;
  logic                 out_ready_xi;
  logic [WIDTH-1:0]     f_xo;
  logic                 zf_xo;
  logic                 of_xo;
  logic                 err_xo;
  logic                 busy_xo;
  logic [LED_SEL_W-1:0] led_sel_xi;
  logic [7:0]           led_xo;

  modport master (
    output in_valid_xi, op_xi, a_xi, b_xi, out_ready_xi, led_sel_xi,
    input  in_ready_xo, out_valid_xo, f_xo, zf_xo, of_xo, err_xo, busy_xo, led_xo
  );

  modport slave (
    input  in_valid_xi, op_xi, a_xi, b_xi, out_ready_xi, led_sel_xi,
    output in_ready_xo, out_valid_xo, f_xo, zf_xo, of_xo, err_xo, busy_xo, led_xo
  );
endinterface

// File: rtl/seq_alu_led_mux.sv
// seq_alu_led_mux
// Selects what the 8 LEDs show: one byte of the held result, or the flag byte.
//   f       in  WIDTH      held result
//   zf/of/err/busy in 1    status flags
//   sel     in  LED_SEL_W  0..WIDTH/8-1 result byte (0 = LSB), WIDTH/8 flag byte
//   led     out 8          LED drive, 0 for any other select value
module seq_alu_led_mux
  import seq_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LED_SEL_W = $clog2(WIDTH/8 + 1)
) (
  input  logic [WIDTH-1:0]     f,
  input  logic                 zf,
  input  logic                 of,
  input  logic                 err,
  input  logic                 busy,
  input  logic [LED_SEL_W-1:0] sel,
  output logic [7:0]           led
);

  localparam int NUM_BYTES = WIDTH / 8;

  logic [7:0] flag_byte;

  always_comb begin
    flag_byte                = '0;
    flag_byte[FLAG_ZF_BIT]   = zf;
    flag_byte[FLAG_OF_BIT]   = of;
    flag_byte[FLAG_ERR_BIT]  = err;
    flag_byte[FLAG_BUSY_BIT] = busy;
  end

  // Compare against each legal select value so no variable part-select is needed
  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (sel == LED_SEL_W'(i)) led = f[i*8 +: 8];
    end
    if (sel == LED_SEL_W'(NUM_BYTES)) led = flag_byte;
  end

endmodule

// File: rtl/seq_alu_unit.sv
// seq_alu_unit
// Handshaked multi-function ALU: logic, add/sub, signed compare and shifts in
// one execute cycle; unsigned shift-add multiply over WIDTH+1 cycles. The
// result and its flags are held until consumed.
//   clk_xi    in  clock, rising edge
//   rst_n_xi  in  asynchronous active-low reset
//   bus       seq_alu_if.slave : operand/result handshakes, flags, busy, LEDs
// Build option: define SEQ_ALU_MUL_EN to include the multiplier (opcode 10);
// without it opcode 10 is reported as illegal and busy_xo is constant 0.
module seq_alu_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LED_SEL_W = $clog2(WIDTH/8 + 1)
) (
  input  logic    clk_xi,
  input  logic    rst_n_xi,
  seq_alu_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] f_q;
  logic             zf_q, of_q, err_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of, alu_err;
  logic [WIDTH-1:0] sum, diff;
  logic [SH_W-1:0]  sh;
  logic             accept;
  logic [7:0]       led;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SH_W-1:0]    cnt;
  logic               mul_fin;
`endif

  assign accept = (state_q == IDLE) && bus.in_valid_xi;
  assign sum    = a_q + b_q;
  assign diff   = a_q - b_q;
  assign sh     = b_q[SH_W-1:0];

  // State register
  always_ff @(posedge clk_xi or negedge rst_n_xi) begin
    if (!rst_n_xi) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: multiplies take the MULT loop, everything else (including
  // illegal opcodes) goes through the single EXEC cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
`ifdef SEQ_ALU_MUL_EN
          if (bus.op_xi == OP_MUL) state_d = MULT;
`endif
        end
      end
      EXEC: state_d = DONE;
`ifdef SEQ_ALU_MUL_EN
      MULT: if (mul_fin) state_d = DONE;
`endif
      DONE: if (bus.out_ready_xi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ALU evaluated from the captured operands during EXEC
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_res = a_q << sh;
      OP_SRL: alu_res = a_q >> sh;
      OP_SRA: alu_res = $unsigned($signed(a_q) >>> sh);
      default: alu_err = 1'b1;
    endcase
  end

  // Operand capture, multiply iterations and result/flag registers. Results
  // only move on the edge that enters DONE, so they hold through consumption.
  // The multiply spends one extra cycle after its last iteration so the
  // result is registered from a settled accumulator rather than through the adder.
  always_ff @(posedge clk_xi or negedge rst_n_xi) begin
    if (!rst_n_xi) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      mul_fin <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q    <= bus.op_xi;
        a_q     <= bus.a_xi;
        b_q     <= bus.b_xi;
`ifdef SEQ_ALU_MUL_EN
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, bus.a_xi};
        mplier  <= bus.b_xi;
        cnt     <= SH_W'(WIDTH - 1);
        mul_fin <= 1'b0;
`endif
      end
      if (state_q == EXEC) begin
        f_q   <= alu_res;
        zf_q  <= (alu_res == '0);
        of_q  <= alu_of;
        err_q <= alu_err;
      end
`ifdef SEQ_ALU_MUL_EN
      if (state_q == MULT) begin
        if (mul_fin) begin
          f_q   <= acc[WIDTH-1:0];
          zf_q  <= (acc[WIDTH-1:0] == '0);
          of_q  <= |acc[2*WIDTH-1:WIDTH];
          err_q <= 1'b0;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) mul_fin <= 1'b1;
          else           cnt     <= cnt - 1'b1;
        end
      end
`endif
    end
  end

  assign bus.in_ready_xo  = (state_q == IDLE);
  assign bus.out_valid_xo = (state_q == DONE);
  assign bus.f_xo         = f_q;
  assign bus.zf_xo        = zf_q;
  assign bus.of_xo        = of_q;
  assign bus.err_xo       = err_q;
`ifdef SEQ_ALU_MUL_EN
  assign bus.busy_xo      = (state_q == MULT);
`else
  assign bus.busy_xo      = 1'b0;
`endif
  assign bus.led_xo       = led;

  seq_alu_led_mux #(
    .WIDTH     (WIDTH),
    .LED_SEL_W (LED_SEL_W)
  ) u_led_mux (
    .f    (f_q),
    .zf   (zf_q),
    .of   (of_q),
    .err  (err_q),
    .busy (bus.busy_xo),
    .sel  (bus.led_sel_xi),
    .led  (led)
  );

endmodule
